// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register: resolves rs1/rs2 forwarding at capture time and
// holds ALU operands, opcode and writeback control for the EX stage.
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   id_*   : decoded instruction + valid/ready handshake from ID
//   mem_fwd_* / wb_fwd_* : forwarding sources from EX/MEM and MEM/WB
//   ex_*   : registered ALU operands/opcode/writeback control + handshake

package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
endpackage

module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    input  logic                  id_src_a_pc_i,
    input  logic                  id_src_b_imm_i,
    input  alu_op_e               id_alu_op_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_rd_we_i,
    input  logic                  mem_fwd_we_i,
    input  logic [REG_ADDR_W-1:0] mem_fwd_rd_i,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data_i,
    input  logic                  wb_fwd_we_i,
    input  logic [REG_ADDR_W-1:0] wb_fwd_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [DATA_WIDTH-1:0] ex_operand_a_o,
    output logic [DATA_WIDTH-1:0] ex_operand_b_o,
    output logic [DATA_WIDTH-1:0] ex_store_data_o,
    output alu_op_e               ex_alu_op_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic                  ex_rd_we_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] st_q, st_d;
    alu_op_e               alu_op_q, alu_op_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  rd_we_q, rd_we_d;

    logic                  capture;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // x0 is hardwired zero; MEM is younger than WB so it takes priority.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [REG_ADDR_W-1:0] idx,
        input logic [DATA_WIDTH-1:0] rf
    );
        if (idx == '0)
            return '0;
        else if (mem_fwd_we_i && (mem_fwd_rd_i == idx))
            return mem_fwd_data_i;
        else if (wb_fwd_we_i && (wb_fwd_rd_i == idx))
            return wb_fwd_data_i;
        else
            return rf;
    endfunction

    assign id_ready_o = !valid_q || ex_ready_i;
    assign capture    = id_valid_i && id_ready_o && !flush_i;
    assign fwd_rs1    = resolve(id_rs1_addr_i, id_rs1_data_i);
    assign fwd_rs2    = resolve(id_rs2_addr_i, id_rs2_data_i);

    always_comb begin
        valid_d  = valid_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        st_d     = st_q;
        alu_op_d = alu_op_q;
        rd_d     = rd_q;
        rd_we_d  = rd_we_q;

        if (capture) begin
            valid_d  = 1'b1;
            op_a_d   = id_src_a_pc_i ? id_pc_i : fwd_rs1;
            op_b_d   = id_src_b_imm_i ? id_imm_i : fwd_rs2;
            st_d     = fwd_rs2;
            alu_op_d = id_alu_op_i;
            rd_d     = id_rd_addr_i;
            rd_we_d  = id_rd_we_i;
        end else if (flush_i || ex_ready_i) begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            st_q     <= '0;
            alu_op_q <= ALU_ADD;
            rd_q     <= '0;
            rd_we_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            st_q     <= st_d;
            alu_op_q <= alu_op_d;
            rd_q     <= rd_d;
            rd_we_q  <= rd_we_d;
        end
    end

    assign ex_valid_o      = valid_q;
    assign ex_operand_a_o  = op_a_q;
    assign ex_operand_b_o  = op_b_q;
    assign ex_store_data_o = st_q;
    assign ex_alu_op_o     = alu_op_q;
    assign ex_rd_addr_o    = rd_q;
    // Write enable never escapes without a valid instruction behind it.
    assign ex_rd_we_o      = rd_we_q && valid_q;

endmodule
